// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-segment driver: latches a hex word, scans one digit per slot.
// Optional decimal-point support is enabled by defining DISP_DP_EN.
module disp_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef DISP_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int TW   = $clog2(SCAN_DIV);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
`ifdef DISP_DP_EN
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
`endif

  generate
    if (NUM_DIGITS < 1) begin : g_chk_digits
      $fatal(1, "disp_scan_mux: NUM_DIGITS must be >= 1");
    end
    if (SCAN_DIV < 2) begin : g_chk_div
      $fatal(1, "disp_scan_mux: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_chk_blank
      $fatal(1, "disp_scan_mux: BLANK_CYC must be in 0..SCAN_DIV-1");
    end
  endgenerate

  logic [TW-1:0]           tick_cnt, tick_nxt;
  logic [IDXW-1:0]         digit_idx, digit_nxt;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   lz;
  logic [3:0]              nib;
  logic                    blanking, sup, all_zero;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;
`ifdef DISP_DP_EN
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    dp_req, dp_raw;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    tick_nxt  = tick_cnt + 1'b1;
    digit_nxt = digit_idx;
    if (tick_cnt == TW'(SCAN_DIV - 1)) begin
      tick_nxt = '0;
      if (NUM_DIGITS > 1)
        digit_nxt = (digit_idx == IDXW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end
  end

  // lz[i] marks digit i as a leading zero: it and every digit above it are zero
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (value_q[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end
  end

  // Outputs are computed for the slot position the counters move to on this edge
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit_nxt == IDXW'(i)) nib = value_q[4*i +: 4];
    blanking = (BLANK_CYC > 0) && (tick_nxt < TW'(BLANK_CYC));
    sup      = blank_lz && lz[digit_nxt];
    an_raw   = '0;
    seg_raw  = '0;
`ifdef DISP_DP_EN
    dp_req = dp_q[digit_nxt];
    dp_raw = 1'b0;
    if (!blanking) begin
      if (!sup || dp_req) an_raw[digit_nxt] = 1'b1;
      if (!sup) seg_raw = decode(nib);
      dp_raw = dp_req;
    end
`else
    if (!blanking && !sup) begin
      an_raw[digit_nxt] = 1'b1;
      seg_raw           = decode(nib);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      digit_idx <= '0;
      value_q   <= '0;
      seg       <= SEG_INV;
      an        <= AN_INV;
`ifdef DISP_DP_EN
      dp_q      <= '0;
      dp        <= DP_INV;
`endif
    end else begin
      tick_cnt  <= tick_nxt;
      digit_idx <= digit_nxt;
      if (load) value_q <= value;
      seg       <= seg_raw ^ SEG_INV;
      an        <= an_raw ^ AN_INV;
`ifdef DISP_DP_EN
      if (load) dp_q <= dp_in;
      dp        <= dp_raw ^ DP_INV;
`endif
    end
  end

endmodule
